// File: rtl/cmp_arbiter.sv
// Round-robin arbiter that shares one magnitude comparator between NREQ requesters,
// sequencing chip-select/ready handshakes and guarding each compare with a watchdog.
module cmp_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [2:0]        result,
    output logic              err,
    output logic              busy,
    output logic              cmp_cs,
    output logic [W-1:0]      cmp_a,
    output logic [W-1:0]      cmp_b,
    input  logic [2:0]        cmp_out,
    input  logic              cmp_rdy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // wdog counts completed cycles in ISSUE/WAIT, so the TIMEOUT-th cycle is the last one.
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ABORT,
        S_DONE
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   pick;
    logic [IW:0]     scan;
    logic            hit;
    logic [7:0]      wdog;
    logic [W-1:0]    a_slice [NREQ];
    logic [W-1:0]    b_slice [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign a_slice[i] = req_a[i*W +: W];
        assign b_slice[i] = req_b[i*W +: W];
    end

    // Search starts at the pointer and wraps; first active request wins.
    always_comb begin
        pick = ptr;
        hit  = 1'b0;
        scan = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + (IW+1)'(k);
            if (scan >= (IW+1)'(NREQ)) scan = scan - (IW+1)'(NREQ);
            if (!hit && req[scan[IW-1:0]]) begin
                hit  = 1'b1;
                pick = scan[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ptr    <= '0;
            winner <= '0;
            wdog   <= '0;
            gnt    <= '0;
            done   <= '0;
            result <= 3'b000;
            err    <= 1'b0;
            busy   <= 1'b0;
            cmp_cs <= 1'b0;
            cmp_a  <= '0;
            cmp_b  <= '0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hit) begin
                        winner <= pick;
                        gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                        cmp_a  <= a_slice[pick];
                        cmp_b  <= b_slice[pick];
                        cmp_cs <= 1'b1;
                        busy   <= 1'b1;
                        wdog   <= '0;
                        state  <= S_ISSUE;
                    end
                end
                // rdy is high while the comparator idles, so only its falling edge means "accepted".
                S_ISSUE: begin
                    if (!cmp_rdy) begin
                        wdog  <= '0;
                        state <= S_WAIT;
                    end else if (wdog >= WD_LIMIT) begin
                        cmp_cs <= 1'b0;
                        result <= 3'b000;
                        state  <= S_ABORT;
                    end else begin
                        wdog <= (wdog == 8'hFF) ? wdog : wdog + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (cmp_rdy) begin
                        result <= cmp_out;
                        cmp_cs <= 1'b0;
                        done   <= gnt;
                        state  <= S_DONE;
                    end else if (wdog >= WD_LIMIT) begin
                        cmp_cs <= 1'b0;
                        result <= 3'b000;
                        state  <= S_ABORT;
                    end else begin
                        wdog <= (wdog == 8'hFF) ? wdog : wdog + 8'd1;
                    end
                end
                S_ABORT: begin
                    done  <= gnt;
                    err   <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= (winner == IW'(NREQ-1)) ? '0 : winner + 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Randomized self-checking bench for cmp_arbiter with a behavioural comparator
// and a round-robin reference model.
module tb_cmp_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [NREQ-1:0]   gnt, done;
    logic [2:0]        result;
    logic              err, busy, cmp_cs;
    logic [W-1:0]      cmp_a, cmp_b;
    logic [2:0]        cmp_out;
    logic              cmp_rdy;

    int vectors     = 0;
    int miscompares = 0;
    int ptr_m       = 0;

    int         cst;
    logic [2:0] cval;
    bit         stuck    = 1'b0;
    bit         force_en = 1'b0;
    logic [2:0] force_val = 3'b000;

    cmp_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .done(done), .result(result), .err(err), .busy(busy),
        .cmp_cs(cmp_cs), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_out(cmp_out), .cmp_rdy(cmp_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_cmp(input logic [15:0] a, input logic [15:0] b);
        if (a > b) return 3'b100;
        if (a < b) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int pick_m(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [15:0] slice_a(input int i);
        return req_a[i*W +: W];
    endfunction

    function automatic logic [15:0] slice_b(input int i);
        return req_b[i*W +: W];
    endfunction

    // Comparator: idle(rdy=1) -> busy one cycle (rdy=0) -> result one cycle -> idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cst  <= 0;
            cval <= 3'b000;
        end else begin
            case (cst)
                0: if (cmp_cs && !stuck) begin
                    cst  <= 1;
                    cval <= ref_cmp(cmp_a, cmp_b);
                end
                1: cst <= 2;
                default: cst <= 0;
            endcase
        end
    end
    assign cmp_rdy = (cst != 1);
    assign cmp_out = (cst == 2) ? (force_en ? force_val : cval) : 3'b000;

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic wait_gnt(input int max, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < max) begin
            @(negedge clk);
            cyc++;
            if (gnt != '0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int max, output int cyc, output int cs_cnt, output bit ok);
        cyc    = 0;
        cs_cnt = 0;
        ok     = 1'b0;
        while (cyc < max) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin ok = 1'b1; break; end
            if (cmp_cs) cs_cnt++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req   = '0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({gnt, done, result, err, busy, cmp_cs} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got gnt=%b done=%b res=%b err=%b busy=%b cs=%b want all 0", gnt, done, result, err, busy, cmp_cs);
        end
        vectors++;
        if ({cmp_a, cmp_b} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_ops: got a=%h b=%h want 0", cmp_a, cmp_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int cyc, csn;
        bit ok;
        set_ops(0, 16'h1234, 16'h0FFF);
        req = 4'b0001;
        wait_gnt(10, cyc, ok);
        vectors++;
        if (!ok || gnt !== 4'b0001 || cmp_cs !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_gnt: got gnt=%b cs=%b busy=%b want 0001/1/1", gnt, cmp_cs, busy);
        end
        vectors++;
        if (cyc != 1) begin
            miscompares++;
            $display("[TB] FAIL single_gnt_lat: got %0d want 1", cyc);
        end
        wait_done(40, cyc, csn, ok);
        vectors++;
        if (!ok || cyc != 3 || csn + 1 != 3) begin
            miscompares++;
            $display("[TB] FAIL single_timing: got lat=%0d cs_cycles=%0d want 3/3", cyc, csn + 1);
        end
        vectors++;
        if (done !== 4'b0001 || result !== 3'b100 || err !== 1'b0 || cmp_cs !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_result: got done=%b res=%b err=%b cs=%b want 0001/100/0/0", done, result, err, cmp_cs);
        end
        ptr_m = 1;
        req = '0;
        @(negedge clk);
        vectors++;
        if (done !== '0 || busy !== 1'b0 || gnt !== '0) begin
            miscompares++;
            $display("[TB] FAIL single_pulse: got done=%b busy=%b gnt=%b want 0/0/0", done, busy, gnt);
        end
    endtask

    task automatic test_results;
        logic [15:0] av [2];
        logic [15:0] bv [2];
        logic [2:0]  ev [2];
        int cyc, csn;
        bit ok;
        av[0] = 16'hFFFF; bv[0] = 16'hFFFF; ev[0] = 3'b001;
        av[1] = 16'h0000; bv[1] = 16'h8000; ev[1] = 3'b010;
        for (int p = 0; p < 2; p++) begin
            set_ops(2, av[p], bv[p]);
            req = 4'b0100;
            wait_gnt(10, cyc, ok);
            vectors++;
            if (!ok || gnt !== 4'b0100 || cmp_a !== av[p] || cmp_b !== bv[p]) begin
                miscompares++;
                $display("[TB] FAIL results_gnt%0d: got gnt=%b a=%h b=%h want 0100/%h/%h", p, gnt, cmp_a, cmp_b, av[p], bv[p]);
            end
            wait_done(40, cyc, csn, ok);
            vectors++;
            if (!ok || cyc != 3 || done !== 4'b0100 || result !== ev[p] || err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL results_done%0d: got lat=%0d done=%b res=%b err=%b want 3/0100/%b/0", p, cyc, done, result, ev[p], err);
            end
            ptr_m = 3;
            req = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin;
        int cyc, csn, exp;
        bit ok;
        logic [NREQ-1:0] eg;
        for (int i = 0; i < NREQ; i++) set_ops(i, 16'($urandom), 16'($urandom));
        req = '1;
        for (int t = 0; t < 5; t++) begin
            exp = pick_m(req, ptr_m);
            eg  = NREQ'(1) << exp;
            wait_gnt(10, cyc, ok);
            vectors++;
            if (!ok || cyc != 1 || gnt !== eg || cmp_a !== slice_a(exp) || cmp_b !== slice_b(exp)) begin
                miscompares++;
                $display("[TB] FAIL rr_gnt%0d: got gnt=%b lat=%0d a=%h want %b/1/%h", t, gnt, cyc, cmp_a, eg, slice_a(exp));
            end
            wait_done(40, cyc, csn, ok);
            vectors++;
            if (!ok || cyc != 3 || done !== eg || result !== ref_cmp(slice_a(exp), slice_b(exp))) begin
                miscompares++;
                $display("[TB] FAIL rr_done%0d: got lat=%0d done=%b res=%b want 3/%b/%b", t, cyc, done, result, eg, ref_cmp(slice_a(exp), slice_b(exp)));
            end
            ptr_m = (exp + 1) % NREQ;
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || gnt !== '0 || done !== '0) begin
                miscompares++;
                $display("[TB] FAIL rr_gap%0d: got busy=%b gnt=%b done=%b want 0/0/0", t, busy, gnt, done);
            end
            if (t == 4) req = '0;
            else for (int i = 0; i < NREQ; i++) set_ops(i, 16'($urandom), 16'($urandom));
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int cyc, csn, exp;
        bit ok;
        logic [NREQ-1:0] eg;
        logic [15:0] ea, eb;
        req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                ea = 16'($urandom);
                set_ops(i, ea, ($urandom_range(0, 3) == 0) ? ea : 16'($urandom));
            end
            exp = pick_m(req, ptr_m);
            eg  = NREQ'(1) << exp;
            ea  = slice_a(exp);
            eb  = slice_b(exp);
            wait_gnt(10, cyc, ok);
            vectors++;
            if (!ok || gnt !== eg || cmp_a !== ea || cmp_b !== eb) begin
                miscompares++;
                $display("[TB] FAIL rand_gnt%0d: got gnt=%b a=%h b=%h want %b/%h/%h", t, gnt, cmp_a, cmp_b, eg, ea, eb);
            end
            for (int i = 0; i < NREQ; i++) set_ops(i, 16'($urandom), 16'($urandom));
            req = req | NREQ'($urandom);
            wait_done(40, cyc, csn, ok);
            vectors++;
            if (!ok || cyc != 3 || done !== eg || result !== ref_cmp(ea, eb) || err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rand_done%0d: got lat=%0d done=%b res=%b err=%b want 3/%b/%b/0", t, cyc, done, result, err, eg, ref_cmp(ea, eb));
            end
            ptr_m = (exp + 1) % NREQ;
            req[exp] = 1'b0;
            if (req == '0) req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int cyc, csn;
        bit ok;
        stuck = 1'b1;
        set_ops(1, 16'h0033, 16'h0044);
        req = 4'b0010;
        wait_gnt(10, cyc, ok);
        vectors++;
        if (!ok || gnt !== 4'b0010 || cmp_cs !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL tmo_gnt: got gnt=%b cs=%b want 0010/1", gnt, cmp_cs);
        end
        wait_done(60, cyc, csn, ok);
        vectors++;
        if (!ok || cyc != TIMEOUT + 1 || csn + 1 != TIMEOUT) begin
            miscompares++;
            $display("[TB] FAIL tmo_timing: got lat=%0d cs_cycles=%0d want %0d/%0d", cyc, csn + 1, TIMEOUT + 1, TIMEOUT);
        end
        vectors++;
        if (done !== 4'b0010 || result !== 3'b000 || err !== 1'b1 || cmp_cs !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL tmo_result: got done=%b res=%b err=%b cs=%b want 0010/000/1/0", done, result, err, cmp_cs);
        end
        ptr_m = 2;
        req = '0;
        stuck = 1'b0;
        @(negedge clk);
        vectors++;
        if (err !== 1'b0 || done !== '0) begin
            miscompares++;
            $display("[TB] FAIL tmo_pulse: got err=%b done=%b want 0/0", err, done);
        end
        set_ops(1, 16'h0005, 16'h0009);
        req = 4'b0010;
        wait_gnt(10, cyc, ok);
        wait_done(40, cyc, csn, ok);
        vectors++;
        if (!ok || cyc != 3 || done !== 4'b0010 || result !== 3'b010 || err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL tmo_recover: got lat=%0d done=%b res=%b err=%b want 3/0010/010/0", cyc, done, result, err);
        end
        ptr_m = 2;
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc, csn, exp;
        bit ok;
        set_ops(2, 16'hF000, 16'h0001);
        req = 4'b0100;
        wait_gnt(10, cyc, ok);
        wait_done(40, cyc, csn, ok);
        vectors++;
        if (!ok || result !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL rmid_setup: got res=%b want 100", result);
        end
        ptr_m = 3;
        req = '0;
        @(negedge clk);
        set_ops(1, 16'h0100, 16'h0200);
        set_ops(3, 16'h0300, 16'h0100);
        req = 4'b1010;
        exp = pick_m(req, ptr_m);
        wait_gnt(10, cyc, ok);
        vectors++;
        if (!ok || gnt !== NREQ'(1 << exp)) begin
            miscompares++;
            $display("[TB] FAIL rmid_gnt: got gnt=%b want %b", gnt, NREQ'(1 << exp));
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({gnt, done, result, err, busy, cmp_cs} !== '0 || {cmp_a, cmp_b} !== '0) begin
            miscompares++;
            $display("[TB] FAIL rmid_async: got gnt=%b done=%b res=%b err=%b busy=%b cs=%b a=%h b=%h want all 0", gnt, done, result, err, busy, cmp_cs, cmp_a, cmp_b);
        end
        ptr_m = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp = pick_m(req, ptr_m);
        wait_gnt(10, cyc, ok);
        vectors++;
        if (!ok || gnt !== NREQ'(1 << exp) || cmp_a !== slice_a(exp)) begin
            miscompares++;
            $display("[TB] FAIL rmid_regrant: got gnt=%b a=%h want %b/%h", gnt, cmp_a, NREQ'(1 << exp), slice_a(exp));
        end
        wait_done(40, cyc, csn, ok);
        vectors++;
        if (!ok || done !== NREQ'(1 << exp) || result !== ref_cmp(slice_a(exp), slice_b(exp))) begin
            miscompares++;
            $display("[TB] FAIL rmid_done: got done=%b res=%b want %b/%b", done, result, NREQ'(1 << exp), ref_cmp(slice_a(exp), slice_b(exp)));
        end
        ptr_m = (exp + 1) % NREQ;
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_operand_hold;
        int cyc, csn;
        bit ok;
        set_ops(0, 16'h0001, 16'h0002);
        req = 4'b0001;
        wait_gnt(10, cyc, ok);
        set_ops(0, 16'hFFFF, 16'h0002);
        @(negedge clk);
        vectors++;
        if (!ok || cmp_a !== 16'h0001) begin
            miscompares++;
            $display("[TB] FAIL hold_opa: got %h want 0001", cmp_a);
        end
        wait_done(40, cyc, csn, ok);
        vectors++;
        if (!ok || result !== 3'b010 || cmp_a !== 16'h0001 || done !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL hold_result: got res=%b a=%h done=%b want 010/0001/0001", result, cmp_a, done);
        end
        ptr_m = 1;
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_passthrough;
        int cyc, csn;
        bit ok;
        force_en  = 1'b1;
        force_val = 3'b110;
        set_ops(2, 16'h0007, 16'h0001);
        req = 4'b0100;
        wait_gnt(10, cyc, ok);
        wait_done(40, cyc, csn, ok);
        vectors++;
        if (!ok || result !== 3'b110 || err !== 1'b0 || done !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL passthru: got res=%b err=%b done=%b want 110/0/0100", result, err, done);
        end
        ptr_m = 3;
        force_en = 1'b0;
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_single;
        test_results;
        test_round_robin;
        test_random;
        test_timeout;
        test_reset_mid;
        test_operand_hold;
        test_passthrough;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no completion want finish");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
